// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and limits for the bit-serial adder.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// full_adder_structural: one-bit full adder built from two structural half adders.
module half_adder_structural (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    xor g_sum (sum, a, b);
    and g_cout (cout, a, b);

endmodule

module full_adder_structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0, c0, c1;

    half_adder_structural u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
    half_adder_structural u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

    or g_cout (cout, c0, c1);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d, sum_q, sum_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             carry_q, carry_d, carry_out_q, carry_out_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             fa_s, fa_c;

    full_adder_structural u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .cout(fa_c)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        bit_cnt_d   = bit_cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    sum_sh_d  = '0;
                    carry_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                sum_sh_d  = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d   = fa_c;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    sum_d       = sum_sh_d;
                    carry_out_d = fa_c;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            bit_cnt_q   <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized self-checking bench against an a+b reference model.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, carry_out;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       busy1, done1, cout1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb);
        logic [8:0] exp;
        int n, bc;
        exp = {1'b0, xa} + {1'b0, xb};
        start = 1'b1; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        n = 0; bc = 0;
        while (!done && n < 20) begin
            bc += int'(busy);
            @(negedge clk);
            n++;
        end
        check("latency", n, 8);
        check("busy_cycles", bc, 8);
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("sum", sum, exp[7:0]);
        check("carry_out", carry_out, exp[8]);
        @(negedge clk);
        check("done_single", done, 0);
        check("sum_hold", sum, exp[7:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] oa [0:30];
        logic [7:0] ob [0:30];
        logic [8:0] last, ds;
        int dc;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", carry_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h35, 8'h1A);
        run_op(8'hFF, 8'h01);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'h00);

        // Second start during RUN must be ignored.
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        dc = 0; ds = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin dc++; ds = {carry_out, sum}; end
            @(negedge clk);
        end
        check("ign_done_count", dc, 1);
        check("ign_result", ds, 9'h030);

        // Reset on RUN cycle 4 aborts the operation.
        start = 1'b1; a = 8'h77; b = 8'h99;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", carry_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            dc += int'(done);
            @(negedge clk);
        end
        check("abort_no_done", dc, 0);
        run_op(8'h01, 8'h02);

        // Continuous start: acceptance every 10 edges, result from operands at accepting edge.
        last = 9'h003;
        oa[0] = 8'($urandom); ob[0] = 8'($urandom);
        start = 1'b1; a = oa[0]; b = ob[0];
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (j % 10 == 8) last = {1'b0, oa[j-8]} + {1'b0, ob[j-8]};
            check("cont_done", done, (j % 10 == 8) ? 1 : 0);
            check("cont_result", {carry_out, sum}, last);
            oa[j+1] = 8'($urandom); ob[j+1] = 8'($urandom);
            a = oa[j+1]; b = ob[j+1];
        end
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_op(8'($urandom), 8'($urandom));

        // WIDTH=1 instance: half-adder truth table, done two cycles after start.
        for (int k = 0; k < 4; k++) begin
            a1 = 1'(k >> 1); b1 = 1'(k);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy", busy1, 1);
            check("w1_early_done", done1, 0);
            @(negedge clk);
            check("w1_done", done1, 1);
            check("w1_result", {cout1, sum1}, (k >> 1) + (k & 1));
            @(negedge clk);
            check("w1_done_single", done1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
